// File: rtl/sigmadelta_pkg.sv
// Shared sigma-delta constants so the DAC and ADC agree on sample width and period.
package sigmadelta_pkg;
  localparam int SD_DAC_WIDTH   = 8;
  localparam int SD_UPDATE_BITS = 10;
  localparam int SD_INTERP_BITS = 3;
endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: bit_o is the registered carry of acc + level_i.
// One clock from level_i to bit_o; clr (or reset) empties the accumulator and forces bit_o low.
module sd_mod1 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic [W-1:0] level_i,
  output logic         bit_o
);
  logic [W-1:0] acc_q;
  logic         bit_q;
  logic [W:0]   sum_d;

  assign sum_d = {1'b0, acc_q} + {1'b0, level_i};

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      acc_q <= '0;
      bit_q <= 1'b0;
    end else begin
      acc_q <= sum_d[W-1:0];
      bit_q <= sum_d[W];
    end
  end

  assign bit_o = bit_q;
endmodule

// File: rtl/sigmadelta_dac.sv
// First-order sigma-delta DAC: one-entry sample buffer, per-period linear ramp, 1-bit output.
// A sample accepted before tick N starts ramping at tick N and is reached at tick N+1; ready is low while the buffer is full.
module sigmadelta_dac
  import sigmadelta_pkg::*;
#(
  parameter int DAC_WIDTH   = SD_DAC_WIDTH,
  parameter int UPDATE_BITS = SD_UPDATE_BITS,
  parameter int INTERP_BITS = SD_INTERP_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [DAC_WIDTH-1:0] digital_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 sample_req,
  output logic                 underrun,
  output logic                 analog_out
);
  localparam int LW       = DAC_WIDTH + INTERP_BITS;
  localparam int SUB_BITS = UPDATE_BITS - INTERP_BITS;

  logic [UPDATE_BITS-1:0]  counter_q;
  logic                    full_q;
  logic [DAC_WIDTH-1:0]    hold_q;
  logic [DAC_WIDTH-1:0]    base_q;
  logic signed [DAC_WIDTH:0] delta_q;
  logic [LW-1:0]           level_q;
  logic                    sample_req_q;
  logic                    underrun_q;

  logic                    tick;
  logic                    sub_phase;
  logic                    substep;
  logic                    accept;
  logic [DAC_WIDTH-1:0]    new_d;
  logic signed [DAC_WIDTH:0] delta_d;

  assign tick = enable && (&counter_q);

  // Substeps fall on the last count of each 2^SUB_BITS slice; the final slice coincides with tick.
  if (INTERP_BITS == 0) begin : g_nosub
    assign sub_phase = 1'b0;
  end else if (SUB_BITS == 0) begin : g_allsub
    assign sub_phase = 1'b1;
  end else begin : g_sub
    assign sub_phase = &counter_q[SUB_BITS-1:0];
  end

  assign substep      = enable && sub_phase && !tick;
  assign sample_ready = rstn && !full_q;
  assign accept       = sample_valid && sample_ready;
  assign new_d        = full_q ? hold_q : base_q;
  assign delta_d      = $signed({1'b0, new_d}) - $signed({1'b0, base_q});

  always_ff @(posedge clk) begin
    if (!rstn) begin
      counter_q    <= '0;
      full_q       <= 1'b0;
      hold_q       <= '0;
      base_q       <= '0;
      delta_q      <= '0;
      level_q      <= '0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      counter_q    <= enable ? counter_q + 1'b1 : '0;
      sample_req_q <= tick;
      underrun_q   <= tick && !full_q;

      if (tick && full_q) begin
        full_q <= 1'b0;
      end else if (accept) begin
        full_q <= 1'b1;
        hold_q <= digital_in;
      end

      // Snapping to the endpoint at each tick keeps the ramp from accumulating drift.
      if (tick) begin
        level_q <= LW'(base_q) << INTERP_BITS;
        delta_q <= delta_d;
        base_q  <= new_d;
      end else if (substep) begin
        level_q <= level_q + LW'(delta_q);
      end
    end
  end

  assign sample_req = sample_req_q;
  assign underrun   = underrun_q;

  sd_mod1 #(
    .W(LW)
  ) u_mod (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (!enable),
    .level_i(level_q),
    .bit_o  (analog_out)
  );
endmodule

// File: tb/tb_sigmadelta_dac.sv
// Bench for sigmadelta_dac with a small period/ramp: per-cycle scoreboard plus density table and ramp sequences.
module tb_sigmadelta_dac;
  localparam int DW = 8;
  localparam int UB = 4;
  localparam int IB = 2;
  localparam int LW = DW + IB;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] digital_in = '0;
  logic          sample_ready, sample_req, underrun, analog_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigmadelta_dac #(
    .DAC_WIDTH  (DW),
    .UPDATE_BITS(UB),
    .INTERP_BITS(IB)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .digital_in  (digital_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_req  (sample_req),
    .underrun    (underrun),
    .analog_out  (analog_out)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard: expected outputs queued at each edge, popped after it.
  typedef struct packed {
    logic out;
    logic req;
    logic und;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  exp_t c_e;
  int   m_cnt, m_base, m_hold, m_delta, m_level, m_acc, m_nv, m_sum;
  bit   m_full, m_tk, m_sb, m_acpt;

  always @(posedge clk) begin
    m_e = '0;
    if (!rstn) begin
      m_cnt = 0; m_full = 0; m_base = 0; m_hold = 0;
      m_delta = 0; m_level = 0; m_acc = 0;
    end else begin
      m_tk = enable && (m_cnt == (1 << UB) - 1);
      m_sb = enable && ((m_cnt % (1 << (UB - IB))) == (1 << (UB - IB)) - 1) && !m_tk;
      if (enable) begin
        m_sum   = m_acc + m_level;
        m_e.out = (m_sum >= (1 << LW));
        m_acc   = m_sum % (1 << LW);
      end else begin
        m_acc = 0;
      end
      m_e.req = m_tk;
      m_e.und = m_tk && !m_full;
      m_nv    = m_full ? m_hold : m_base;
      m_acpt  = sample_valid && !m_full;
      if (m_tk) begin
        m_level = m_base * (1 << IB);
        m_delta = m_nv - m_base;
        m_base  = m_nv;
      end else if (m_sb) begin
        m_level = m_level + m_delta;
      end
      if (m_tk && m_full) m_full = 0;
      else if (m_acpt) begin
        m_full = 1;
        m_hold = int'(digital_in);
      end
      m_cnt = enable ? (m_cnt + 1) % (1 << UB) : 0;
    end
    q.push_back(m_e);
  end

  always @(negedge clk) begin
    #2;
    if (q.size() > 0) begin
      c_e = q.pop_front();
      check("sb_analog_out", int'(analog_out), int'(c_e.out));
      check("sb_sample_req", int'(sample_req), int'(c_e.req));
      check("sb_underrun", int'(underrun), int'(c_e.und));
    end
    check("sb_sample_ready", int'(sample_ready), int'(rstn && !m_full));
  end

  // Background feeder keeps the buffer topped up with feed_val.
  bit          feed_en = 0;
  logic [DW-1:0] feed_val = '0;
  always @(negedge clk) begin
    if (feed_en) begin
      sample_valid = 1'b1;
      digital_in   = feed_val;
    end
  end

  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sample_req) begin
        ok = 1;
        break;
      end
    end
    check("wait_req_seen", int'(ok), 1);
  endtask

  task automatic run_count(input int n, output int ones, output int reqs, output int unds);
    ones = 0; reqs = 0; unds = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones += int'(analog_out);
      reqs += int'(sample_req);
      unds += int'(underrun);
    end
  endtask

  typedef struct {
    logic [DW-1:0] val;
    int            ones;
  } dens_t;

  dens_t tbl[5];
  int ones, reqs, unds;

  initial begin
    tbl[0] = '{8'h80, 512};
    tbl[1] = '{8'h00, 0};
    tbl[2] = '{8'hFF, 1020};
    tbl[3] = '{8'h01, 4};
    tbl[4] = '{8'h40, 256};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_analog_out", int'(analog_out), 0);
    check("rst_sample_req", int'(sample_req), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_sample_ready", int'(sample_ready), 0);
    check("rst_level", int'(dut.level_q), 0);

    // Ramp up 0x00 -> 0x40, then down 0x40 -> 0x00
    rstn = 1'b1; enable = 1'b1; sample_valid = 1'b1; digital_in = 8'h40;
    #1 check("up_ready_empty", int'(sample_ready), 1);
    @(negedge clk);
    sample_valid = 1'b0;
    #1 check("up_ready_full", int'(sample_ready), 0);
    wait_req();
    check("up_level0", int'(dut.level_q), 'h000);
    check("up_delta", int'($signed(dut.delta_q)), 64);
    sample_valid = 1'b1; digital_in = 8'h00;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("up_level1", int'(dut.level_q), 'h040);
    repeat (4) @(negedge clk);
    check("up_level2", int'(dut.level_q), 'h080);
    repeat (4) @(negedge clk);
    check("up_level3", int'(dut.level_q), 'h0C0);
    repeat (4) @(negedge clk);
    check("dn_req", int'(sample_req), 1);
    check("dn_level0", int'(dut.level_q), 'h100);
    check("dn_delta", int'($signed(dut.delta_q)), -64);
    repeat (4) @(negedge clk);
    check("dn_level1", int'(dut.level_q), 'h0C0);
    repeat (4) @(negedge clk);
    check("dn_level2", int'(dut.level_q), 'h080);
    repeat (4) @(negedge clk);
    check("dn_level3", int'(dut.level_q), 'h040);
    repeat (4) @(negedge clk);
    check("dn_level_end", int'(dut.level_q), 'h000);
    check("dn_underrun", int'(underrun), 1);

    // Back-to-back valids: the second must not be taken
    enable = 1'b0; sample_valid = 1'b1; digital_in = 8'h11;
    #1 check("b2b_ready1", int'(sample_ready), 1);
    @(negedge clk);
    digital_in = 8'h22;
    #1 check("b2b_ready2", int'(sample_ready), 0);
    @(negedge clk);
    sample_valid = 1'b0;
    enable = 1'b1;
    wait_req();
    check("b2b_base", int'(dut.base_q), 'h11);
    check("b2b_no_underrun", int'(underrun), 0);

    // Constant-level density over a full accumulator cycle
    feed_en = 1;
    foreach (tbl[i]) begin
      feed_val = tbl[i].val;
      repeat (64) @(negedge clk);
      run_count(1 << LW, ones, reqs, unds);
      check($sformatf("dens_ones_%02h", tbl[i].val), ones, tbl[i].ones);
      check($sformatf("dens_reqs_%02h", tbl[i].val), reqs, (1 << LW) >> UB);
      check($sformatf("dens_unds_%02h", tbl[i].val), unds, 0);
    end

    // Starvation: one underrun per tick, level holds the last value
    feed_en = 0; sample_valid = 1'b0;
    repeat (20) @(negedge clk);
    run_count(64, ones, reqs, unds);
    check("starve_reqs", reqs, 4);
    check("starve_unds", unds, 4);
    check("starve_level", int'(dut.level_q), 'h100);

    // Disabled: no requests, output low, level retained
    enable = 1'b0;
    run_count(40, ones, reqs, unds);
    check("dis_reqs", reqs, 0);
    check("dis_ones", ones, 0);
    check("dis_level", int'(dut.level_q), 'h100);

    // Reset mid-ramp with a buffered sample
    enable = 1'b1; feed_val = 8'hC0; feed_en = 1;
    wait_req();
    repeat (6) @(negedge clk);
    check("mid_full", int'(sample_ready), 0);
    feed_en = 0; sample_valid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_out", int'(analog_out), 0);
    check("mid_rst_level", int'(dut.level_q), 0);
    check("mid_rst_ready", int'(sample_ready), 0);
    rstn = 1'b1;
    #1 check("mid_post_ready", int'(sample_ready), 1);
    wait_req();
    check("mid_post_underrun", int'(underrun), 1);

    repeat (3) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
